restoring_div_seq: RTL and testbench

Sequential controller for the restoring divider: it accepts an unsigned dividend/divisor pair over a valid/ready handshake. It iterates the combinational shift-subtract step once per clock for WIDTH cycles, holding the partial remainder A, quotient register Q and divisor M between steps. It returns quotient and remainder over a second valid/ready handshake. It sits directly upstream of, and around, the single-step datapath: it feeds that step its A/Q/M each cycle and registers what the step produces.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 41 ++++
 rtl/restoring_div_seq.sv | 119 +++++++++++
 tb/tb_restoring_div_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the restoring divider controller and its
// single-step datapath.
//   state_t      - controller FSM states (IDLE / RUN / DONE)
//   WIDTH_DEF    - default operand width
//   DBZ_QUOT_ALL - all-ones quotient pattern reported for a zero divisor;
//                  users slice the low WIDTH bits
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    localparam logic [63:0] DBZ_QUOT_ALL = '1;

endpackage : div_pkg

// File: rtl/div_step.sv
// div_step: one purely combinational restoring-division step.
// Ports:
//   a      [WIDTH:0]   partial remainder (top bit is the trial-subtract sign)
//   q      [WIDTH-1:0] quotient / remaining dividend bits
//   m      [WIDTH:0]   zero-extended divisor
//   a_next [WIDTH:0]   partial remainder after the step
//   q_next [WIDTH-1:0] quotient register after the step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic        [2*WIDTH:0] aq_sh;
    logic        [WIDTH:0]   a_sh;
    logic        [WIDTH-1:0] q_sh;
    logic signed [WIDTH:0]   a_trial;

    always_comb begin
        aq_sh   = {a, q} << 1;
        a_sh    = aq_sh[2*WIDTH:WIDTH];
        q_sh    = aq_sh[WIDTH-1:0];
        a_trial = $signed(a_sh) - $signed(m);
        // Negative trial result: the subtract did not fit, keep the shifted
        // remainder and shift in a 0 quotient bit.
        if (a_trial[WIDTH]) begin
            a_next = a_sh;
            q_next = q_sh;
        end else begin
            a_next = a_trial;
            q_next = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule : div_step

// File: rtl/restoring_div_seq.sv
// restoring_div_seq: sequential unsigned restoring divider. Accepts one
// dividend/divisor pair, runs WIDTH shift-subtract steps (one per clock via
// div_step) and presents quotient/remainder until the consumer takes them.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   dividend, divisor     unsigned operands [WIDTH-1:0]
//   out_valid / out_ready result handshake
//   quotient, remainder   unsigned results [WIDTH-1:0]
//   div_by_zero           result came from a zero divisor
//   busy                  operation in progress (RUN or DONE)
module restoring_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            count       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= '0;
                        q_reg    <= dividend;
                        m_reg    <= {1'b0, divisor};
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            // Result is known immediately; out_valid follows
                            // one edge later from the DONE state.
                            state       <= DONE;
                            quotient    <= DBZ_QUOT_ALL[WIDTH-1:0];
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            div_by_zero <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_next;
                        remainder <= a_next[WIDTH-1:0];
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule : restoring_div_seq

// File: tb/tb_restoring_div_seq.sv
module tb_restoring_div_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    restoring_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        if (dv == 0) begin
            e.q   = '1;
            e.r   = dd;
            e.dbz = 1'b1;
        end else begin
            e.q   = dd / dv;
            e.r   = dd % dv;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: compare each transferred result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("quotient", int'(quotient), int'(mon_e.q));
                check_eq("remainder", int'(remainder), int'(mon_e.r));
                check_eq("div_by_zero", int'(div_by_zero), int'(mon_e.dbz));
            end
        end
    end

    // One complete transaction; stall = cycles out_ready is held low after out_valid.
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input int stall);
        exp_t e;
        int   t;
        int   lat;
        e = model(dd, dv);
        @(negedge clk);
        out_ready = (stall == 0);
        dividend  = dd;
        divisor   = dv;
        in_valid  = 1'b1;
        sb.push_back(e);
        t = 0;
        while (!in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 0, 1);
            in_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            check_eq("result_timeout", 0, 1);
            return;
        end
        check_eq("latency", lat, (dv == 0) ? 1 : W);
        for (int i = 0; i < stall; i++) begin
            check_eq("hold_valid", int'(out_valid), 1);
            check_eq("hold_quotient", int'(quotient), int'(e.q));
            check_eq("hold_remainder", int'(remainder), int'(e.r));
            check_eq("hold_in_ready", int'(in_ready), 0);
            check_eq("hold_busy", int'(busy), 1);
            @(posedge clk);
            #1;
            if (i == stall - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("post_xfer_valid", int'(out_valid), 0);
        check_eq("post_xfer_in_ready", int'(in_ready), 1);
        check_eq("post_xfer_busy", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        int stall;

        // Reset state
        #12;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_quotient", int'(quotient), 0);
        check_eq("rst_remainder", int'(remainder), 0);
        check_eq("rst_dbz", int'(div_by_zero), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 1);

        // Basic, divide-by-zero, back-pressure
        run_op(8'd200, 8'd7, 0);
        run_op(8'd173, 8'd0, 0);
        run_op(8'd100, 8'd10, 5);

        // Back-to-back: second request waits for the first result transfer
        @(negedge clk);
        out_ready = 1'b1;
        dividend  = 8'd255;
        divisor   = 8'd1;
        in_valid  = 1'b1;
        sb.push_back(model(8'd255, 8'd1));
        sb.push_back(model(8'd5, 8'd9));
        @(posedge clk);
        @(negedge clk);
        dividend = 8'd5;
        divisor  = 8'd9;
        t = 0;
        while (!in_ready && t < 30) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        check_eq("b2b_accept_gap", t, W + 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 30) begin
            @(posedge clk);
            t++;
            @(negedge clk);
        end
        check_eq("b2b_second_latency", t, W);
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_drained", sb.size(), 0);

        // Reset in the middle of a run: no result may appear
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_quotient", int'(quotient), 0);
        check_eq("midrst_remainder", int'(remainder), 0);
        check_eq("midrst_dbz", int'(div_by_zero), 0);
        check_eq("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) t++;
        end
        check_eq("midrst_no_stale", t, 0);
        run_op(8'd9, 8'd3, 0);

        // Corner operands
        run_op(8'd0, 8'd0, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd0, 8'd5, 0);
        run_op(8'd1, 8'd255, 1);
        run_op(8'd255, 8'd0, 2);
        run_op(8'd254, 8'd128, 0);

        // Randomized sweep
        for (int n = 0; n < 1500; n++) begin
            dd = W'($urandom_range(0, 255));
            dv = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
            stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(dd, dv, stall);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_restoring_div_seq
